// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    CTRL_WAIT = 2'd1,
    DRAIN     = 2'd2,
    HALTED    = 2'd3
  } hctrl_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // x0 is hard-wired, so it never carries a dependency.
  function automatic logic is_live_reg(input logic [4:0] addr);
    return addr != REG_ZERO;
  endfunction

endpackage

// File: rtl/hazard_ctrl_scoreboard.sv
// Per-register in-flight writer counters with two busy read ports and a full
// flag for the destination of the instruction trying to issue.
module hazard_ctrl_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int RFADDR = 5,
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc_en,
  input  logic [RFADDR-1:0] inc_addr,
  input  logic              dec_en,
  input  logic [RFADDR-1:0] dec_addr,
  input  logic [RFADDR-1:0] rd_addr_a,
  input  logic [RFADDR-1:0] rd_addr_b,
  input  logic [RFADDR-1:0] full_addr,
  output logic              busy_a,
  output logic              busy_b,
  output logic              full
);

  localparam int NREG = 1 << RFADDR;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [PEND_W-1:0] pend [NREG];
  logic [NREG-1:0]   inc_hit;
  logic [NREG-1:0]   dec_hit;

  always_comb begin
    inc_hit = '0;
    dec_hit = '0;
    for (int i = 1; i < NREG; i++) begin
      inc_hit[i] = inc_en && (inc_addr == RFADDR'(i));
      dec_hit[i] = dec_en && (dec_addr == RFADDR'(i));
    end
  end

  // A same-cycle issue and retire of one register cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        pend[i] <= '0;
      end
    end else begin
      pend[0] <= '0;
      for (int i = 1; i < NREG; i++) begin
        if (inc_hit[i] && !dec_hit[i]) begin
          if (pend[i] != PEND_MAX) begin
            pend[i] <= pend[i] + 1'b1;
          end
        end else if (dec_hit[i] && !inc_hit[i]) begin
          if (pend[i] != '0) begin
            pend[i] <= pend[i] - 1'b1;
          end
        end
      end
    end
  end

  assign busy_a = pend[rd_addr_a] != '0;
  assign busy_b = pend[rd_addr_b] != '0;
  assign full   = pend[full_addr] == PEND_MAX;

  // A retire with no recorded writer means the pipeline lost track of an instruction.
  a_no_underflow : assert property (@(posedge clk) disable iff (reset)
    (dec_en && dec_addr != '0) |-> (pend[dec_addr] != '0));

endmodule

// File: rtl/hazard_ctrl.sv
// Issue/stall/flush/redirect sequencing for the 5-stage core.
// Optional stall counter built only when HAZARD_PERF_CNT_EN is defined.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// RUN       | normal issue; stalls on RAW or full scoreboard entry
// CTRL_WAIT | jump/branch in flight; fetch frozen until it resolves at WB
// DRAIN     | ecall in flight; waiting for it to retire
// HALTED    | ecall retired; everything frozen until reset
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int RFADDR = 5,
  parameter int PEND_W = 2,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [RFADDR-1:0] id_rs1,
  input  logic [RFADDR-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_rf_wr_en,
  input  logic [RFADDR-1:0] id_rd,
  input  logic              id_ctrl,
  input  logic              id_ecall,
  input  logic              wb_rf_wr_en,
  input  logic [RFADDR-1:0] wb_rd,
  input  logic              wb_ctrl,
  input  logic              wb_ecall,
  output logic              issue,
  output logic              idex_bubble,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              pc_en,
  output logic              pc_redirect,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cycles
);

  hctrl_state_t state, state_nxt;

  logic busy_rs1, busy_rs2, rd_full;
  logic rs1_live, rs2_live, rd_live;
  logic hazard;
  logic sb_inc, sb_dec;

  assign rs1_live = is_live_reg(5'(id_rs1));
  assign rs2_live = is_live_reg(5'(id_rs2));
  assign rd_live  = is_live_reg(5'(id_rd));

  // A writer whose destination counter is saturated waits like a RAW stall.
  assign hazard = id_valid &&
                  ((id_use_rs1 && rs1_live && busy_rs1) ||
                   (id_use_rs2 && rs2_live && busy_rs2) ||
                   (id_rf_wr_en && rd_live && rd_full));

  assign sb_inc = issue && id_rf_wr_en && rd_live;
  assign sb_dec = wb_rf_wr_en && is_live_reg(5'(wb_rd));

  hazard_ctrl_scoreboard #(
    .RFADDR (RFADDR),
    .PEND_W (PEND_W)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .inc_en    (sb_inc),
    .inc_addr  (id_rd),
    .dec_en    (sb_dec),
    .dec_addr  (wb_rd),
    .rd_addr_a (id_rs1),
    .rd_addr_b (id_rs2),
    .full_addr (id_rd),
    .busy_a    (busy_rs1),
    .busy_b    (busy_rs2),
    .full      (rd_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    issue       = 1'b0;
    idex_bubble = 1'b1;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b1;
    pc_en       = 1'b0;
    pc_redirect = 1'b0;
    halted      = 1'b0;

    unique case (state)
      RUN: begin
        issue       = id_valid && !hazard;
        pc_en       = !hazard;
        ifid_en     = !hazard;
        idex_bubble = !issue;
        ifid_flush  = issue && (id_ctrl || id_ecall);
        if (issue && id_ctrl) begin
          state_nxt = CTRL_WAIT;
        end else if (issue && id_ecall) begin
          state_nxt = DRAIN;
        end
      end
      CTRL_WAIT: begin
        if (wb_ctrl) begin
          pc_en       = 1'b1;
          pc_redirect = 1'b1;
          state_nxt   = RUN;
        end
      end
      DRAIN: begin
        if (wb_ecall) begin
          state_nxt = HALTED;
        end
      end
      HALTED: begin
        halted = 1'b1;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase

    if (reset) begin
      state_nxt   = RUN;
      issue       = 1'b0;
      idex_bubble = 1'b1;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      pc_en       = 1'b0;
      pc_redirect = 1'b0;
      halted      = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (id_valid && !issue && (state != HALTED) && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

  // Control/ecall can only reach WB after the FSM left RUN for it.
  a_no_stray_wb : assert property (@(posedge clk) disable iff (reset)
    (state == RUN) |-> !(wb_ctrl || wb_ecall));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a pipeline-level reference model predicts
// every cycle's outputs; a monitor compares them on the falling edge.
module tb_hazard_ctrl;

  localparam int RFADDR = 5;
  localparam int PEND_W = 2;
  localparam int CNT_W  = 32;

  localparam int M_RUN = 0, M_CW = 1, M_DRAIN = 2, M_HALT = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic id_valid = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic id_rf_wr_en = 1'b0, id_ctrl = 1'b0, id_ecall = 1'b0;
  logic [RFADDR-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0, wb_rd = '0;
  logic wb_rf_wr_en = 1'b0, wb_ctrl = 1'b0, wb_ecall = 1'b0;
  logic issue, idex_bubble, ifid_en, ifid_flush, pc_en, pc_redirect, halted;
  logic [CNT_W-1:0] stall_cycles;

  always #5 clk = ~clk;

  hazard_ctrl #(.RFADDR(RFADDR), .PEND_W(PEND_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rf_wr_en(id_rf_wr_en), .id_rd(id_rd), .id_ctrl(id_ctrl), .id_ecall(id_ecall),
    .wb_rf_wr_en(wb_rf_wr_en), .wb_rd(wb_rd), .wb_ctrl(wb_ctrl), .wb_ecall(wb_ecall),
    .issue(issue), .idex_bubble(idex_bubble), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .pc_en(pc_en), .pc_redirect(pc_redirect), .halted(halted), .stall_cycles(stall_cycles)
  );

  typedef struct {
    bit valid, u1, u2, wr, ctrl, ecall;
    int rs1, rs2, rd;
  } instr_t;

  typedef struct {
    bit issue, bubble, ifen, flush, pc_en, redir, halted;
    longint stall;
  } exp_t;

  exp_t   exp_q[$];
  int     vectors = 0;
  int     miscompares = 0;

  // Reference model: instructions flow EX -> MEM -> WB; pend counts issued,
  // not-yet-retired writers per register.
  int     mode = M_RUN;
  int     pend[32];
  longint stall_m = 0;
  instr_t ex_s, mem_s, wb_s, nop;
  bit     last_issue, last_ifen, last_flush;

  function automatic instr_t mk(bit v, bit u1, int rs1, bit u2, int rs2,
                                bit wr, int rd, bit ctrl, bit ecall);
    instr_t r;
    r.valid = v; r.u1 = u1; r.rs1 = rs1; r.u2 = u2; r.rs2 = rs2;
    r.wr = wr; r.rd = rd; r.ctrl = ctrl; r.ecall = ecall;
    return r;
  endfunction

  function automatic instr_t rnd_instr(bit allow_ecall);
    instr_t r;
    int k;
    r.valid = $urandom_range(0, 9) < 8;
    r.u1    = $urandom_range(0, 1) == 1;
    r.rs1   = $urandom_range(0, 7);
    r.u2    = $urandom_range(0, 1) == 1;
    r.rs2   = $urandom_range(0, 7);
    r.wr    = $urandom_range(0, 3) != 0;
    r.rd    = $urandom_range(0, 7);
    k       = $urandom_range(0, 99);
    r.ctrl  = k < 8;
    r.ecall = allow_ecall && k >= 8 && k < 10;
    return r;
  endfunction

  task automatic step(input instr_t id, input bit rst);
    exp_t e;
    bit   haz, iss, wbw, wbc, wbe;
    @(posedge clk);
    #1;
    wbw = wb_s.valid && wb_s.wr;
    wbc = wb_s.valid && wb_s.ctrl;
    wbe = wb_s.valid && wb_s.ecall;
    reset       = rst;
    id_valid    = id.valid;
    id_rs1      = 5'(id.rs1);
    id_rs2      = 5'(id.rs2);
    id_use_rs1  = id.u1;
    id_use_rs2  = id.u2;
    id_rf_wr_en = id.wr;
    id_rd       = 5'(id.rd);
    id_ctrl     = id.ctrl;
    id_ecall    = id.ecall;
    wb_rf_wr_en = wbw;
    wb_rd       = 5'(wb_s.rd);
    wb_ctrl     = wbc;
    wb_ecall    = wbe;

    e.issue = 0; e.bubble = 1; e.ifen = 0; e.flush = 1;
    e.pc_en = 0; e.redir = 0; e.halted = 0;
`ifdef HAZARD_PERF_CNT_EN
    e.stall = stall_m;
`else
    e.stall = 0;
`endif
    iss = 0;
    haz = id.valid && ((id.u1 && id.rs1 != 0 && pend[id.rs1] > 0) ||
                       (id.u2 && id.rs2 != 0 && pend[id.rs2] > 0) ||
                       (id.wr && id.rd != 0 && pend[id.rd] >= 3));
    if (!rst) begin
      case (mode)
        M_RUN: begin
          iss = id.valid && !haz;
          e.issue = iss; e.pc_en = !haz; e.ifen = !haz;
          e.bubble = !iss; e.flush = iss && (id.ctrl || id.ecall);
        end
        M_CW:   if (wbc) begin e.pc_en = 1; e.redir = 1; end
        M_HALT: e.halted = 1;
        default: ;
      endcase
    end
    exp_q.push_back(e);
    last_issue = e.issue; last_ifen = e.ifen; last_flush = e.flush;

    if (rst) begin
      mode = M_RUN;
      foreach (pend[i]) pend[i] = 0;
      stall_m = 0;
      ex_s = nop; mem_s = nop; wb_s = nop;
    end else begin
      if (id.valid && !iss && mode != M_HALT && stall_m < 64'hFFFF_FFFF) stall_m++;
      if (iss && id.wr && id.rd != 0) pend[id.rd]++;
      if (wbw && wb_s.rd != 0) pend[wb_s.rd]--;
      case (mode)
        M_RUN:   if (iss && id.ctrl) mode = M_CW; else if (iss && id.ecall) mode = M_DRAIN;
        M_CW:    if (wbc) mode = M_RUN;
        M_DRAIN: if (wbe) mode = M_HALT;
        default: ;
      endcase
      wb_s = mem_s; mem_s = ex_s; ex_s = iss ? id : nop;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s at vector %0d: got %0h expected %0h", name, vectors, act, expv);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        chk("issue", 64'(issue), 64'(e.issue));
        chk("idex_bubble", 64'(idex_bubble), 64'(e.bubble));
        chk("ifid_en", 64'(ifid_en), 64'(e.ifen));
        chk("ifid_flush", 64'(ifid_flush), 64'(e.flush));
        chk("pc_en", 64'(pc_en), 64'(e.pc_en));
        chk("pc_redirect", 64'(pc_redirect), 64'(e.redir));
        chk("halted", 64'(halted), 64'(e.halted));
        chk("stall_cycles", 64'(stall_cycles), 64'(e.stall));
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(nop, 0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(nop, 1);
  endtask

  // Hold an instruction in ID until the model says it issues.
  task automatic present(input instr_t ins, input string tag);
    int n = 0;
    do begin
      step(ins, 0);
      n++;
    end while (!last_issue && n < 40);
    if (!last_issue) begin
      miscompares++;
      $display("FAIL %s: no issue within 40 cycles", tag);
    end
  endtask

  task automatic wait_run(input string tag);
    int n = 0;
    while (mode != M_RUN && n < 20) begin
      step(nop, 0);
      n++;
    end
    if (mode != M_RUN) begin
      miscompares++;
      $display("FAIL %s: model stuck in mode %0d", tag, mode);
    end
  endtask

  initial begin : stim
    instr_t cur;
    int     halt_cnt;
    bit     rst;
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ex_s = nop; mem_s = nop; wb_s = nop;
    foreach (pend[i]) pend[i] = 0;
    repeat (2) @(posedge clk);
    do_reset(2);

    // RAW on x5, then release one cycle after the retire
    present(mk(1, 0, 0, 0, 0, 1, 5, 0, 0), "raw_producer");
    present(mk(1, 1, 5, 0, 0, 0, 0, 0, 0), "raw_consumer");
    // x0 never stalls
    present(mk(1, 0, 0, 0, 0, 1, 0, 0, 0), "x0_producer");
    present(mk(1, 1, 0, 1, 0, 0, 0, 0, 0), "x0_consumer");
    idle(4);
    // Branch resolved at WB three cycles after issue
    present(mk(1, 0, 0, 0, 0, 0, 0, 1, 0), "branch");
    wait_run("branch_wait");
    idle(1);
    // Same-cycle issue and retire of x7
    present(mk(1, 0, 0, 0, 0, 1, 7, 0, 0), "sim_first");
    idle(2);
    present(mk(1, 0, 0, 0, 0, 1, 7, 0, 0), "sim_second");
    present(mk(1, 0, 0, 1, 7, 0, 0, 0, 0), "sim_consumer");
    idle(4);
    // Fourth writer to x9 waits on a saturated counter
    for (int i = 0; i < 4; i++) present(mk(1, 0, 0, 0, 0, 1, 9, 0, 0), "full_writer");
    idle(4);
    // Reset while waiting on a branch with x3 twice in flight
    present(mk(1, 0, 0, 0, 0, 1, 3, 0, 0), "rst_w1");
    present(mk(1, 0, 0, 0, 0, 1, 3, 0, 0), "rst_w2");
    present(mk(1, 0, 0, 0, 0, 0, 0, 1, 0), "rst_branch");
    step(mk(1, 1, 3, 0, 0, 0, 0, 0, 0), 0);
    do_reset(1);
    present(mk(1, 1, 3, 0, 0, 0, 0, 0, 0), "post_reset");
    idle(4);
    // Ecall drains, halts, stays halted, then reset recovers
    present(mk(1, 0, 0, 0, 0, 0, 0, 0, 1), "ecall");
    idle(5);
    for (int i = 0; i < 20; i++) step(mk(1, 0, 0, 0, 0, 1, 2, 0, 0), 0);
    do_reset(1);
    idle(2);

    // Randomized traffic with occasional resets and ecall halts
    cur = rnd_instr(1);
    halt_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = (mode == M_HALT && halt_cnt > 4) || ($urandom_range(0, 199) == 0);
      step(cur, rst);
      halt_cnt = (mode == M_HALT) ? halt_cnt + 1 : 0;
      if (rst || last_issue || last_ifen || last_flush) cur = rnd_instr(1);
    end

    idle(2);
    @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB). Holds a register scoreboard and a small FSM. Decides each cycle whether the decoded instruction issues into EX, whether fetch advances, and when wrong-path fetches are flushed. Handles RAW stalls, control-transfer redirects (resolved at WB) and ecall drain/halt.

Parameters:
RFADDR, 5, register-file address width
PEND_W, 2, per-register in-flight counter width (max 3 writers in EX/MEM/WB)
CNT_W, 32, stall performance counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  IF/ID register holds a valid instruction
id_rs1  in  RFADDR  source register 1 of decoded instruction
id_rs2  in  RFADDR  source register 2
id_use_rs1  in  1  instruction reads rs1
id_use_rs2  in  1  instruction reads rs2
id_rf_wr_en  in  1  instruction writes rd
id_rd  in  RFADDR  destination register
id_ctrl  in  1  jump/branch (next PC resolved at WB)
id_ecall  in  1  ecall
wb_rf_wr_en  in  1  WB-stage register write this cycle
wb_rd  in  RFADDR  WB-stage destination
wb_ctrl  in  1  WB stage holds the outstanding control instruction
wb_ecall  in  1  WB stage holds the ecall
issue  out  1  ID->EX transfer of decoded instruction
idex_bubble  out  1  load NOP into ID/EX register
ifid_en  out  1  IF/ID register load enable
ifid_flush  out  1  clear IF/ID valid
pc_en  out  1  PC register load enable
pc_redirect  out  1  PC loads WB-resolved next PC (taken target or retiring inc_pc)
halted  out  1  core halted after ecall retire
stall_cycles  out  CNT_W  stall counter (see Optional Feature)

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- State: FSM {RUN, CTRL_WAIT, DRAIN, HALTED}; scoreboard pend[0..31], PEND_W bits each.
- Reset: state=RUN, all pend=0, stall_cycles=0. While reset is high: issue=0, pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1, pc_redirect=0, halted=0.
- hazard = id_valid && ((id_use_rs1 && id_rs1!=0 && pend[id_rs1]!=0) || (id_use_rs2 && id_rs2!=0 && pend[id_rs2]!=0)).
- No WB bypass: a retire in cycle N clears the hazard from cycle N+1.
- RUN:
  - issue = id_valid && !hazard.
  - pc_en = ifid_en = !hazard.
  - idex_bubble = !issue.
  - Issue with id_ctrl: ifid_flush=1; next state CTRL_WAIT.
  - Issue with id_ecall: ifid_flush=1; next state DRAIN.
  - Otherwise ifid_flush=0.
- CTRL_WAIT:
  - issue=0, idex_bubble=1, ifid_flush=1, pc_en=0.
  - On wb_ctrl: pc_en=1, pc_redirect=1, next state RUN.
- DRAIN:
  - issue=0, idex_bubble=1, pc_en=0, ifid_flush=1.
  - On wb_ecall: next state HALTED.
- HALTED:
  - halted=1; all enables 0, bubble=1.
  - Sticky until reset.
- Scoreboard update:
  - Increment pend[id_rd] on issue && id_rf_wr_en && id_rd!=0.
  - Decrement pend[wb_rd] on wb_rf_wr_en && wb_rd!=0.
  - Same register in both in the same cycle: no change.
  - Decrement at 0: hold 0; flag an assertion error.
  - Increment at max: stall instead (treated as hazard).
  - pend[0] is always 0.
- pc_redirect is asserted only in CTRL_WAIT.
- A wb_ctrl or wb_ecall seen in RUN is ignored; assertion error.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: stall_cycles increments each cycle with id_valid && !issue && state!=HALTED. Saturates at all-ones; cleared by reset.
- Undefined: stall_cycles is tied to 0 and no counter flops are built.

Decomposition:
- lib_pkg: hctrl_state_t enum (RUN, CTRL_WAIT, DRAIN, HALTED); constant REG_ZERO=5'd0.
- Sub-module scoreboard: pend array, inc/dec ports, two read ports returning busy flags and a full flag.
- FSM and output logic remain in hazard_ctrl.

Test Plan:
- RAW: issue rd=5, then id_rs1=5 with use_rs1 → issue=0 and pc_en=0 until wb_rf_wr_en/wb_rd=5 at cycle N; issue=1 at N+1.
- x0: issue rd=0, then rs1=0 consumer → no stall; pend stays 0.
- Branch: id_ctrl issues at cycle T → ifid_flush=1 at T; state CTRL_WAIT; pc_en=0 until wb_ctrl at T+3 → pc_en=1 and pc_redirect=1 at T+3; RUN at T+4.
- Ecall: id_ecall issues → DRAIN; wb_ecall → halted=1 next cycle; issue stays 0 for 20 cycles; reset → halted=0.
- Simultaneous: issue rd=7 while WB retires rd=7 with pend[7]=1 → pend[7] stays 1; consumer of x7 still stalls.
- Reset mid CTRL_WAIT with pend[3]=2 → state RUN, pend all 0, stall_cycles=0; first valid instruction issues immediately.
